product_regbank: RTL and testbench

- Parametrised, double-buffered product register bank for the TLUT matrix-multiply datapath.
- Captures N_IN accumulator-width values into any subset of N_SLOT slots per cycle, in overwrite or accumulate mode with optional saturation.
- Ping-pong banks let the compute side fill one bank while the other is streamed out, one slot column per beat, over a valid/ready interface toward the adder-tree / output stage.

---
 rtl/product_regbank.sv | 161 ++++++++++++++++
 tb/tb_product_regbank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/product_regbank.sv
// product_regbank
//   Double-buffered product register bank. The compute side writes N_IN
//   values into any subset of N_SLOT slots of the write bank each cycle,
//   either overwriting or accumulating, with optional saturation. A swap
//   hands the write bank to the read side. The read side then streams it out
//   one slot per beat over a valid/ready interface.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      per-slot write enable
//   acc_mode   0 = overwrite, 1 = accumulate
//   clear      zero the whole write bank, combined with this cycle's write
//   in         N_IN input values; in[i] lands in entry [i] of each enabled slot
//   swap_req   level request to swap banks
//   swap_done  one-cycle pulse after a swap is accepted
//   rd_valid   read beat available
//   rd_ready   downstream accepts the beat
//   rd_data    read_bank[i][rd_slot] for every i (combinational)
//   rd_slot    slot index of the current beat
//   rd_last    current beat is the final slot
//   busy       a drain is in progress
module product_regbank #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned N_SLOT        = 4,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter bit          SAT           = 1'b1,
    parameter bit          CLEAR_ON_SWAP = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_SLOT-1:0]                             wr_en,
    input  logic                                          acc_mode,
    input  logic                                          clear,
    input  logic [N_IN-1:0][ACC_WIDTH-1:0]                in,
    input  logic                                          swap_req,
    output logic                                          swap_done,
    output logic                                          rd_valid,
    input  logic                                          rd_ready,
    output logic [N_IN-1:0][ACC_WIDTH-1:0]                rd_data,
    output logic [((N_SLOT > 1) ? $clog2(N_SLOT) : 1)-1:0] rd_slot,
    output logic                                          rd_last,
    output logic                                          busy
);

    localparam int unsigned SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_SLOT - 1);
    localparam logic [ACC_WIDTH-1:0] MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_V = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SW-1:0]    r_slot;
    logic [SW-1:0]    w_slot_nxt;
    logic             r_wsel;
    logic             w_accept;

    logic [ACC_WIDTH-1:0] r_bank  [2][N_SLOT][N_IN];
    logic [ACC_WIDTH-1:0] w_wnext [N_SLOT][N_IN];

    // Next contents of the write bank.
    always_comb begin
        logic [ACC_WIDTH-1:0] v_base;
        logic [ACC_WIDTH:0]   v_sum;
        logic [ACC_WIDTH-1:0] v_acc;
        for (int unsigned j = 0; j < N_SLOT; j++) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                v_base = clear ? '0 : r_bank[r_wsel][j][i];
                // One extra bit: the top two bits disagree exactly on overflow.
                v_sum  = {v_base[ACC_WIDTH-1], v_base} + {in[i][ACC_WIDTH-1], in[i]};
                if (SAT && (v_sum[ACC_WIDTH] != v_sum[ACC_WIDTH-1]))
                    v_acc = v_sum[ACC_WIDTH] ? MIN_V : MAX_V;
                else
                    v_acc = v_sum[ACC_WIDTH-1:0];
                if (wr_en[j])
                    w_wnext[j][i] = acc_mode ? v_acc : in[i];
                else
                    w_wnext[j][i] = v_base;
            end
        end
    end

    // The outgoing bank takes this cycle's write even on a swap edge; only the
    // incoming bank is optionally zeroed. The read bank is otherwise never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned j = 0; j < N_SLOT; j++)
                    for (int unsigned i = 0; i < N_IN; i++)
                        r_bank[b][j][i] <= '0;
        end else begin
            for (int unsigned j = 0; j < N_SLOT; j++)
                for (int unsigned i = 0; i < N_IN; i++)
                    r_bank[r_wsel][j][i] <= w_wnext[j][i];
            if (w_accept && CLEAR_ON_SWAP) begin
                for (int unsigned j = 0; j < N_SLOT; j++)
                    for (int unsigned i = 0; i < N_IN; i++)
                        r_bank[~r_wsel][j][i] <= '0;
            end
        end
    end

    // Drain sequencing. A swap request seen during DRAIN simply waits for IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (swap_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_slot_nxt  = '0;
                end
            end
            S_DRAIN: begin
                if (rd_ready) begin
                    if (r_slot == LAST_SLOT) begin
                        w_slot_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_wsel    <= 1'b0;
            swap_done <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_slot    <= w_slot_nxt;
            if (w_accept)
                r_wsel <= ~r_wsel;
            swap_done <= w_accept;
            rd_valid  <= (w_state_nxt == S_DRAIN);
            busy      <= (w_state_nxt == S_DRAIN);
            rd_last   <= (w_state_nxt == S_DRAIN) && (w_slot_nxt == LAST_SLOT);
        end
    end

    assign rd_slot = r_slot;

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++)
            rd_data[i] = r_bank[~r_wsel][r_slot][i];
    end

endmodule

// File: tb/tb_product_regbank.sv
module tb_product_regbank;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       wr_en;
    logic             acc_mode;
    logic             clear;
    logic [1:0][7:0]  in_v;
    logic             swap_req;
    logic             rd_ready;

    logic             swap_done, rd_valid, rd_last, busy;
    logic [1:0][7:0]  rd_data;
    logic [1:0]       rd_slot;

    logic             w_swap_done, w_rd_valid, w_rd_last, w_busy;
    logic [1:0][7:0]  w_rd_data;
    logic [1:0]       w_rd_slot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_regbank #(
        .N_IN(2), .N_SLOT(3), .ACC_WIDTH(8), .SAT(1'b1), .CLEAR_ON_SWAP(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .acc_mode(acc_mode), .clear(clear),
        .in(in_v), .swap_req(swap_req), .swap_done(swap_done), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_slot(rd_slot),
        .rd_last(rd_last), .busy(busy)
    );

    product_regbank #(
        .N_IN(2), .N_SLOT(3), .ACC_WIDTH(8), .SAT(1'b0), .CLEAR_ON_SWAP(1'b1)
    ) dut_wrap (
        .clk(clk), .rst(rst), .wr_en(wr_en), .acc_mode(acc_mode), .clear(clear),
        .in(in_v), .swap_req(swap_req), .swap_done(w_swap_done), .rd_valid(w_rd_valid),
        .rd_ready(rd_ready), .rd_data(w_rd_data), .rd_slot(w_rd_slot),
        .rd_last(w_rd_last), .busy(w_busy)
    );

    typedef struct {
        logic       rst;
        logic [2:0] we;
        logic       acc;
        logic       clr;
        logic [7:0] a0, a1;
        logic       sreq;
        logic       rdy;
        logic       v;
        logic       dn;
        logic [1:0] s;
        logic       l;
        logic [7:0] d0, d1;
        logic [7:0] w0, w1;
    } vec_t;

    vec_t tv[$];

    task automatic add(input int r, input logic [2:0] we, input int acc, input int clr,
                       input int a0, input int a1, input int sreq, input int rdy,
                       input int v, input int dn, input int s, input int l,
                       input int d0, input int d1, input int w0, input int w1);
        vec_t t;
        t.rst = 1'(r);   t.we = we;        t.acc = 1'(acc);  t.clr = 1'(clr);
        t.a0 = 8'(a0);   t.a1 = 8'(a1);    t.sreq = 1'(sreq); t.rdy = 1'(rdy);
        t.v = 1'(v);     t.dn = 1'(dn);    t.s = 2'(s);      t.l = 1'(l);
        t.d0 = 8'(d0);   t.d1 = 8'(d1);    t.w0 = 8'(w0);    t.w1 = 8'(w1);
        tv.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pulse;
        int second_pulse;

        // rst,we,acc,clr,a0,a1,sreq,rdy | valid,done,slot,last | d0,d1 (sat) w0,w1 (wrap)
        // Overwrite drain: slots 0 and 2 written.
        add(0, 3'b101, 0, 0,   5,   -3, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    5,   -3,   5,  -3);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 2, 1,    5,   -3,   5,  -3);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        // Accumulate twice into slot1: saturate vs wrap.
        add(0, 3'b010, 1, 0, 100, -100, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b010, 1, 0, 100, -100, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,  127, -128, -56,  56);
        // Backpressure held at slot1 for four cycles.
        for (int k = 0; k < 4; k++)
            add(0, 3'b000, 0, 0, 0,  0, 0, 0,  1, 0, 1, 0,  127, -128, -56,  56);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 2, 1,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        // Swap with a same-cycle write, then a swap request held through the drain.
        add(0, 3'b001, 0, 0,  11,   22, 1, 1,  1, 1, 0, 0,   11,   22,  11,  22);
        add(0, 3'b100, 0, 0,  33,   44, 1, 1,  1, 0, 1, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 0, 2, 1,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 2, 1,   33,   44,  33,  44);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        // clear + accumulate on slot1 holding 7.
        add(0, 3'b011, 0, 0,   7,    7, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b010, 1, 1,   4,    4, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,    4,    4,   4,   4);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 2, 1,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        // Bank cleared on swap drains zeros (slot2 formerly held 33,44).
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 2, 1,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        // Reset in the middle of a drain.
        add(0, 3'b111, 0, 0,   9,    9, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    9,    9,   9,   9);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,    9,    9,   9,   9);
        add(1, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 1, 1,  1, 1, 0, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 1, 0,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  1, 0, 2, 1,    0,    0,   0,   0);
        add(0, 3'b000, 0, 0,   0,    0, 0, 1,  0, 0, 0, 0,    0,    0,   0,   0);

        // Initial reset.
        rst = 1'b1; wr_en = '0; acc_mode = 1'b0; clear = 1'b0; in_v = '0;
        swap_req = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, int'(rd_valid), 0);
        chk("rst_done",  0, int'(swap_done), 0);
        chk("rst_slot",  0, int'(rd_slot), 0);
        chk("rst_last",  0, int'(rd_last), 0);
        chk("rst_busy",  0, int'(busy), 0);

        foreach (tv[n]) begin
            @(negedge clk);
            rst      = tv[n].rst;
            wr_en    = tv[n].we;
            acc_mode = tv[n].acc;
            clear    = tv[n].clr;
            in_v[0]  = tv[n].a0;
            in_v[1]  = tv[n].a1;
            swap_req = tv[n].sreq;
            rd_ready = tv[n].rdy;
            @(posedge clk);
            #1;
            chk("valid", n, int'(rd_valid),  int'(tv[n].v));
            chk("done",  n, int'(swap_done), int'(tv[n].dn));
            chk("slot",  n, int'(rd_slot),   int'(tv[n].s));
            chk("last",  n, int'(rd_last),   int'(tv[n].l));
            chk("busy",  n, int'(busy),      int'(tv[n].v));
            if (tv[n].v) begin
                chk("data0",      n, int'(rd_data[0]),   int'(tv[n].d0));
                chk("data1",      n, int'(rd_data[1]),   int'(tv[n].d1));
                chk("wrap_data0", n, int'(w_rd_data[0]), int'(tv[n].w0));
                chk("wrap_data1", n, int'(w_rd_data[1]), int'(tv[n].w1));
            end
        end

        // swap_req held high: one swap_done every N_SLOT+1 cycles.
        @(negedge clk);
        rst = 1'b0; wr_en = '0; acc_mode = 1'b0; clear = 1'b0; in_v = '0;
        swap_req = 1'b1; rd_ready = 1'b1;
        first_pulse  = -1;
        second_pulse = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (swap_done) begin
                if (first_pulse < 0)       first_pulse = k;
                else if (second_pulse < 0) second_pulse = k;
            end
            @(negedge clk);
        end
        chk("tput_first", 0, first_pulse, 0);
        chk("tput_gap",   0, second_pulse - first_pulse, 4);

        swap_req = 1'b0;
        for (int k = 0; k < 8 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        chk("final_idle", 0, int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
